// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between the I/O register block (master) and the frame transmitter (slave).
// The master owns start/data/len. The slave owns busy/done/tx.
interface uart_tx_frame_if #(
    parameter int MAX_BYTES = 8
);
    localparam int LW = $clog2(MAX_BYTES + 1);

    // start is a request, not a valid/ready pair: it is taken only when the
    // transmitter is idle and len is non-zero. busy covers the whole frame,
    // and done pulses once in the cycle busy falls.
    logic                   start;
    logic [8*MAX_BYTES-1:0] data;
    logic [LW-1:0]          len;
    logic                   busy;
    logic                   done;
    logic                   tx;

    modport master (output start, output data, output len,
                    input  busy,  input  done, input  tx);
    modport slave  (input  start, input  data, input  len,
                    output busy,  output done, output tx);
endinterface

// File: rtl/uart_tx_frame.sv
// Multi-byte UART transmitter with an internal baud divider, configurable stop bits and a busy/done handshake.
// Defining UART_TX_PARITY_EN adds an even-parity bit after the data bits of each byte.
module uart_tx_frame #(
    parameter int BAUD_DIV  = 434,
    parameter int MAX_BYTES = 8,
    parameter int STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_frame_if.slave     bus,
    output logic [2:0]         state_dbg
);
    localparam int LW = $clog2(MAX_BYTES + 1);
    localparam int IW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int BW = $clog2(BAUD_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_t;
`endif

    state_t                 state;
    logic [8*MAX_BYTES-1:0] frame_data;
    logic [IW-1:0]          idx;
    logic [BW-1:0]          baud_cnt;
    logic [2:0]             bit_cnt;
    logic                   stop_cnt;
    logic                   tx_r;
    logic                   busy_r;
    logic                   done_r;

    logic                   bit_end;
    logic [LW-1:0]          len_clamp;
    logic [IW-1:0]          idx_init;
    logic [7:0]             cur_byte;
    logic                   accept;

    always_comb begin
        bit_end   = (baud_cnt == BW'(BAUD_DIV - 1));
        len_clamp = (bus.len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : bus.len;
        idx_init  = IW'(len_clamp - LW'(1));
        cur_byte  = frame_data[{idx, 3'b000} +: 8];
        accept    = bus.start && (state == S_IDLE) && (bus.len != '0);
    end

    // Every output is registered so tx changes only on bit boundaries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            frame_data <= '0;
            idx        <= '0;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;

            if (state == S_IDLE || state == S_DONE) begin
                baud_cnt <= '0;
            end else if (bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        frame_data <= bus.data;
                        idx        <= idx_init;
                        state      <= S_START;
                        tx_r       <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end

                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                        tx_r    <= cur_byte[0];
                    end
                end

                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx_r  <= ^cur_byte;
`else
                            state    <= S_STOP;
                            tx_r     <= 1'b1;
                            stop_cnt <= 1'b0;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            tx_r    <= cur_byte[bit_cnt + 3'd1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state    <= S_STOP;
                        tx_r     <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                end
`endif

                S_STOP: begin
                    if (bit_end) begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            // Next start bit follows the last stop bit with no idle gap.
                            if (idx != '0) begin
                                idx   <= idx - IW'(1);
                                state <= S_START;
                                tx_r  <= 1'b0;
                            end else begin
                                state  <= S_DONE;
                                done_r <= 1'b1;
                                busy_r <= 1'b0;
                                tx_r   <= 1'b1;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state  <= S_IDLE;
                    tx_r   <= 1'b1;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx    = tx_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign state_dbg = state;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a waveform-level reference model checked every cycle, plus literal frame checks.
// Build with UART_TX_PARITY_EN defined to cover the parity configuration (two stop bits).
module tb_uart_tx_frame;
    localparam int BD = 4;
    localparam int MB = 8;
`ifdef UART_TX_PARITY_EN
    localparam int SB = 2;
    localparam int P  = 1;
`else
    localparam int SB = 1;
    localparam int P  = 0;
`endif
    localparam int NBITS = 10 + P + SB - 1;
    localparam int NB    = NBITS * BD;

    logic       clk;
    logic       rst_n;
    logic [2:0] state_dbg;
    int         checks = 0;
    int         errors = 0;
    bit         cmp_en = 0;

    uart_tx_frame_if #(.MAX_BYTES(MB)) bus();

    uart_tx_frame #(.BAUD_DIV(BD), .MAX_BYTES(MB), .STOP_BITS(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected line/handshake value of every future cycle.
    // Entry encoding {done, tx}; busy is high for every non-done entry.
    logic [1:0] exp_q[$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;

    function automatic void build_frame(input logic [63:0] d, input logic [3:0] l);
        int le;
        logic [7:0] b;
        le = (l > 4'(MB)) ? MB : int'(l);
        for (int k = le - 1; k >= 0; k--) begin
            b = d[8*k +: 8];
            for (int c = 0; c < BD; c++) exp_q.push_back(2'b00);
            for (int i = 0; i < 8; i++)
                for (int c = 0; c < BD; c++) exp_q.push_back({1'b0, b[i]});
            if (P == 1)
                for (int c = 0; c < BD; c++) exp_q.push_back({1'b0, ^b});
            for (int c = 0; c < BD * SB; c++) exp_q.push_back(2'b01);
        end
        exp_q.push_back(2'b11);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_tx   <= 1'b1;
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            if (exp_q.size() == 0 && !m_done && bus.start && bus.len != '0)
                build_frame(bus.data, bus.len);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                m_done <= e[1];
                m_busy <= ~e[1];
                m_tx   <= e[0];
            end else begin
                m_tx   <= 1'b1;
                m_busy <= 1'b0;
                m_done <= 1'b0;
            end
        end
    end

    // Scoreboard: compare every cycle away from the active edge
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            checks++;
            if ({bus.done, bus.busy, bus.tx} !== {m_done, m_busy, m_tx}) begin
                errors++;
                $display("FAIL cycle_cmp t=%0t actual done/busy/tx=%b%b%b expected=%b%b%b",
                         $time, bus.done, bus.busy, bus.tx, m_done, m_busy, m_tx);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Driver: mid-bit samples of tx land in cap_q
    logic cap_q[$];

    task automatic run_frame(input logic [63:0] d, input logic [3:0] l, input bit hold,
                             output int cyc, output int dn);
        bus.start = 1'b1;
        bus.data  = d;
        bus.len   = l;
        cap_q.delete();
        cyc = 0;
        dn  = 0;
        for (int g = 0; g < 5000 && dn == 0; g++) begin
            @(negedge clk);
            if (!hold) bus.start = 1'b0;
            bus.data = {$urandom, $urandom};
            if (bus.busy) begin
                if (cyc % BD == BD / 2) cap_q.push_back(bus.tx);
                cyc++;
            end
            if (bus.done) dn++;
        end
        if (dn == 0) check("done_timeout", 64'(dn), 64'd1);
        @(negedge clk);
        bus.start = 1'b0;
        if (bus.busy) cyc++;
        if (bus.done) dn++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.busy) cyc++;
            if (bus.done) dn++;
        end
    endtask

    function automatic logic [63:0] decode(input int nbytes);
        logic [63:0] v;
        logic [7:0]  b;
        v = '0;
        for (int j = 0; j < nbytes; j++) begin
            b = '0;
            for (int i = 0; i < 8; i++)
                if (j * NBITS + 1 + i < cap_q.size()) b[i] = cap_q[j * NBITS + 1 + i];
            v = (v << 8) | 64'(b);
        end
        return v;
    endfunction

    function automatic logic [11:0] first_bits();
        logic [11:0] v;
        v = '0;
        for (int i = 0; i < NBITS && i < cap_q.size(); i++) v[NBITS - 1 - i] = cap_q[i];
        return v;
    endfunction

    initial begin
        int cyc, dn, cnt, l, le;
        logic [63:0] d, mask;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.data  = '0;
        bus.len   = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", 64'(bus.tx), 64'd1);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        #1 rst_n = 1'b1;
        cmp_en = 1;
        @(negedge clk);

        // Single byte A5
        run_frame(64'hA5, 4'd1, 1'b0, cyc, dn);
`ifdef UART_TX_PARITY_EN
        check("a5_bits", 64'(first_bits()), 64'b010100101011);
`else
        check("a5_bits", 64'(first_bits()), 64'b0101001011);
`endif
        check("a5_busy_cycles", 64'(cyc), 64'(NB));
        check("a5_done_count", 64'(dn), 64'd1);

        // Three bytes, highest index first
        run_frame(64'h123456, 4'd3, 1'b0, cyc, dn);
        check("multi_bytes", decode(3), 64'h123456);
        check("multi_cycles", 64'(cyc), 64'(3 * NB));
        check("multi_done_count", 64'(dn), 64'd1);

        // start held through a len=2 frame and through the done cycle
        d = {$urandom, $urandom};
        run_frame(d, 4'd2, 1'b1, cyc, dn);
        check("held_cycles", 64'(cyc), 64'(2 * NB));
        check("held_done_count", 64'(dn), 64'd1);
        check("held_bytes", decode(2), d & 64'hFFFF);

        // len == 0 is never accepted
        bus.start = 1'b1;
        bus.len   = '0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.busy || bus.done) cnt++;
        end
        bus.start = 1'b0;
        check("len0_ignored", 64'(cnt), 64'd0);

        // len above MAX_BYTES clamps to MAX_BYTES
        d = {$urandom, $urandom};
        run_frame(d, 4'd15, 1'b0, cyc, dn);
        check("clamp_cycles", 64'(cyc), 64'(MB * NB));
        check("clamp_bytes", decode(MB), d);
        check("clamp_done_count", 64'(dn), 64'd1);

        // Reset in data bit 3
        bus.start = 1'b1;
        bus.len   = 4'd1;
        bus.data  = 64'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4 + 3 * BD) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tx", 64'(bus.tx), 64'd1);
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) cnt++;
        end
        check("midrst_quiet", 64'(cnt), 64'd0);
        d = 64'($urandom_range(0, 255));
        run_frame(d, 4'd1, 1'b0, cyc, dn);
        check("after_rst_byte", decode(1), d);
        check("after_rst_done", 64'(dn), 64'd1);

`ifdef UART_TX_PARITY_EN
        run_frame(64'h07, 4'd1, 1'b0, cyc, dn);
        check("parity_07", 64'(cap_q[9]), 64'd1);
        check("parity_07_cycles", 64'(cyc), 64'd48);
        run_frame(64'h03, 4'd1, 1'b0, cyc, dn);
        check("parity_03", 64'(cap_q[9]), 64'd0);
`endif

        // Randomized frames
        for (int n = 0; n < 20; n++) begin
            l  = $urandom_range(1, 9);
            le = (l > MB) ? MB : l;
            d  = {$urandom, $urandom};
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_frame(d, 4'(l), 1'($urandom_range(0, 1)), cyc, dn);
            mask = (le == 8) ? '1 : ((64'd1 << (8 * le)) - 64'd1);
            check("rand_bytes", decode(le), d & mask);
            check("rand_cycles", 64'(cyc), 64'(le * NB));
            check("rand_done_count", 64'(dn), 64'd1);
        end

        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
